cordic_pipe: RTL and testbench

// Parametrised, fully pipelined CORDIC engine with valid/ready flow control. It supports two modes per beat:

---
 rtl/cordic_pkg.sv | 37 +++
 rtl/cordic_stage.sv | 89 ++++++++
 rtl/cordic_pipe.sv | 161 ++++++++++++++++
 tb/tb_cordic_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and arctangent table for the CORDIC engine
// Purpose: mode encodings and a constant function producing the per-stage
//          arctangent increments, scaled so that the full circle is 2^aw.
// Ports:   none (package).
package cordic_pkg;

  localparam logic CORDIC_ROT = 1'b0;
  localparam logic CORDIC_VEC = 1'b1;

  // 2*pi with 60 fractional bits (pi = 3.243F6A8885A308D3... hex).
  localparam logic [127:0] TWO_PI_Q60 = 128'h6487_ED51_10B4_611A;

  // round(atan(2^-i) * 2^aw / 2pi). i = 0 is exactly one eighth of the circle;
  // other entries use the atan power series in Q60 (t <= 1/2 converges fast).
  function automatic logic [127:0] atan_lut(input int i, input int aw);
    logic [127:0] a60;
    logic [127:0] term;
    logic [127:0] res;
    int           e;
    a60 = '0;
    res = '0;
    if (i == 0) begin
      res = 128'd1 << (aw - 3);
    end else begin
      for (int k = 0; k < 32; k++) begin
        e = 60 - i * (2 * k + 1);
        if (e >= 0) begin
          term = (128'd1 << e) / 128'(2 * k + 1);
          a60  = (k % 2 == 0) ? a60 + term : a60 - term;
        end
      end
      res = ((a60 << aw) + (TWO_PI_Q60 >> 1)) / TWO_PI_Q60;
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one enabled CORDIC micro-rotation register stage
// Purpose: applies a single shift-add rotation by +/-atan(2^-SHIFT) and
//          registers the result together with valid, mode and tag.
// Ports:   clk, rst_n (async, active low), en (global advance),
//          in_valid/in_mode/in_x/in_y/in_z/in_tag  -> previous stage,
//          out_valid/out_mode/out_x/out_y/out_z/out_tag -> registered result.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int            IW    = 34,
  parameter int            AW    = 32,
  parameter int            TAGW  = 4,
  parameter int            SHIFT = 0,
  parameter logic [AW-1:0] ATAN  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic            in_mode,
  input  logic [IW-1:0]   in_x,
  input  logic [IW-1:0]   in_y,
  input  logic [AW-1:0]   in_z,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  output logic            out_mode,
  output logic [IW-1:0]   out_x,
  output logic [IW-1:0]   out_y,
  output logic [AW-1:0]   out_z,
  output logic [TAGW-1:0] out_tag
);

  logic            valid_q, valid_d;
  logic            mode_q, mode_d;
  logic [IW-1:0]   x_q, x_d;
  logic [IW-1:0]   y_q, y_d;
  logic [AW-1:0]   z_q, z_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [IW-1:0]   x_sh, y_sh;
  logic            d;

  always_comb begin
    x_sh    = $signed(in_x) >>> SHIFT;
    y_sh    = $signed(in_y) >>> SHIFT;
    // d = 1 rotates clockwise. Rotation: drive a negative residual back to 0.
    // Vectoring: push a non-negative y down; z then collects the angle removed.
    d       = (in_mode == CORDIC_VEC) ? ~in_y[IW-1] : in_z[AW-1];
    valid_d = valid_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    tag_d   = tag_q;
    if (en) begin
      valid_d = in_valid;
      mode_d  = in_mode;
      tag_d   = in_tag;
      x_d     = d ? in_x + y_sh : in_x - y_sh;
      y_d     = d ? in_y - x_sh : in_y + x_sh;
      z_d     = d ? in_z + ATAN : in_z - ATAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - fully pipelined rotation/vectoring CORDIC with valid/ready
// Purpose: quadrant pre-rotation stage, NITER micro-rotation stages and output
//          saturation; one beat per cycle, whole pipe stalls on backpressure.
// Ports:   clk, rst_n (async, active low);
//          in_valid/in_ready, in_mode (0 rot, 1 vec), in_x/in_y (WD signed),
//          in_z (AW angle), in_tag (TAGW sideband);
//          out_valid/out_ready, out_x/out_y (saturated), out_z, out_tag, out_mode.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int WD    = 32,
  parameter int AW    = 32,
  parameter int NITER = 16,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [WD-1:0]   in_x,
  input  logic [WD-1:0]   in_y,
  input  logic [AW-1:0]   in_z,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WD-1:0]   out_x,
  output logic [WD-1:0]   out_y,
  output logic [AW-1:0]   out_z,
  output logic [TAGW-1:0] out_tag,
  output logic            out_mode
);

  // Two guard bits hold the ~1.65 CORDIC gain and the negated most-negative input.
  localparam int IW = WD + 2;

  logic            en;
  logic            v0_q, v0_d;
  logic            m0_q, m0_d;
  logic [IW-1:0]   x0_q, x0_d;
  logic [IW-1:0]   y0_q, y0_d;
  logic [AW-1:0]   z0_q, z0_d;
  logic [TAGW-1:0] t0_q, t0_d;
  logic [IW-1:0]   xe, ye;

  logic            stg_valid [NITER+1];
  logic            stg_mode  [NITER+1];
  logic [IW-1:0]   stg_x     [NITER+1];
  logic [IW-1:0]   stg_y     [NITER+1];
  logic [AW-1:0]   stg_z     [NITER+1];
  logic [TAGW-1:0] stg_tag   [NITER+1];

  function automatic logic [WD-1:0] sat(input logic [IW-1:0] v);
    logic [WD-1:0] r;
    if (v[IW-1:WD-1] == {3{v[IW-1]}}) r = v[WD-1:0];
    else if (v[IW-1])                 r = {1'b1, {(WD-1){1'b0}}};
    else                              r = {1'b0, {(WD-1){1'b1}}};
    return r;
  endfunction

  // A full output register is the only thing that can block the pipe, so
  // every stage (bubbles included) shares one enable.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Pre-rotation brings the vector into the right half-plane (|angle| < 90 deg)
  // where the micro-rotations converge.
  always_comb begin
    xe   = {{2{in_x[WD-1]}}, in_x};
    ye   = {{2{in_y[WD-1]}}, in_y};
    v0_d = v0_q;
    m0_d = m0_q;
    x0_d = x0_q;
    y0_d = y0_q;
    z0_d = z0_q;
    t0_d = t0_q;
    if (en) begin
      v0_d = in_valid;
      m0_d = in_mode;
      t0_d = in_tag;
      if (in_mode == CORDIC_VEC) begin
        if (in_x[WD-1]) begin
          x0_d = -xe;
          y0_d = -ye;
          z0_d = {1'b1, {(AW-1){1'b0}}};
        end else begin
          x0_d = xe;
          y0_d = ye;
          z0_d = '0;
        end
      end else begin
        z0_d = {2'b00, in_z[AW-3:0]};
        case (in_z[AW-1:AW-2])
          2'b00:   begin x0_d = xe;  y0_d = ye;  end
          2'b01:   begin x0_d = -ye; y0_d = xe;  end
          2'b10:   begin x0_d = -xe; y0_d = -ye; end
          default: begin x0_d = ye;  y0_d = -xe; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      m0_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
      z0_q <= '0;
      t0_q <= '0;
    end else begin
      v0_q <= v0_d;
      m0_q <= m0_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
      t0_q <= t0_d;
    end
  end

  assign stg_valid[0] = v0_q;
  assign stg_mode[0]  = m0_q;
  assign stg_x[0]     = x0_q;
  assign stg_y[0]     = y0_q;
  assign stg_z[0]     = z0_q;
  assign stg_tag[0]   = t0_q;

  for (genvar k = 0; k < NITER; k++) begin : g_stage
    cordic_stage #(
      .IW   (IW),
      .AW   (AW),
      .TAGW (TAGW),
      .SHIFT(k),
      .ATAN (AW'(atan_lut(k, AW)))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (stg_valid[k]),
      .in_mode  (stg_mode[k]),
      .in_x     (stg_x[k]),
      .in_y     (stg_y[k]),
      .in_z     (stg_z[k]),
      .in_tag   (stg_tag[k]),
      .out_valid(stg_valid[k+1]),
      .out_mode (stg_mode[k+1]),
      .out_x    (stg_x[k+1]),
      .out_y    (stg_y[k+1]),
      .out_z    (stg_z[k+1]),
      .out_tag  (stg_tag[k+1])
    );
  end

  assign out_valid = stg_valid[NITER];
  assign out_mode  = stg_mode[NITER];
  assign out_x     = sat(stg_x[NITER]);
  assign out_y     = sat(stg_y[NITER]);
  assign out_z     = stg_z[NITER];
  assign out_tag   = stg_tag[NITER];

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - scoreboard testbench for cordic_pipe
module tb_cordic_pipe;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [31:0] in_z = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;
  logic [3:0]  out_tag;
  logic        out_mode;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [3:0]  tag;
    logic        mode;
    int          acc_cyc;
    bit          chk_lat;
    bit          chk_real;
    real         rx;
    real         ry;
    real         mag;
    logic [31:0] rz;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] atan_tb[16];
  real         kgain;

  cordic_pipe #(.WD(32), .AW(32), .NITER(16), .TAGW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z),
    .out_tag  (out_tag),
    .out_mode (out_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input real exp, input real tol);
    real diff;
    checks++;
    diff = real'(act) - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0.1f +/- %0.1f", name, act, exp, tol);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    logic [31:0] r;
    if (v > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648) r = 32'h8000_0000;
    else                           r = v[31:0];
    return r;
  endfunction

  function automatic real clampr(input real v);
    real r;
    r = v;
    if (r > 2147483647.0)  r = 2147483647.0;
    if (r < -2147483648.0) r = -2147483648.0;
    return r;
  endfunction

  // Exact model: quadrant fold, then 16 shift-add micro-rotations on wide integers.
  function automatic exp_t model(input logic mode, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [3:0] tag);
    exp_t        e;
    longint      xi, yi, t;
    logic [31:0] zi;
    bit          d;
    xi = longint'($signed(x));
    yi = longint'($signed(y));
    if (mode) begin
      zi = 32'h0;
      if (xi < 0) begin xi = -xi; yi = -yi; zi = 32'h8000_0000; end
    end else begin
      case (z[31:30])
        2'd0: ;
        2'd1: begin t = xi; xi = -yi; yi = t; end
        2'd2: begin xi = -xi; yi = -yi; end
        default: begin t = xi; xi = yi; yi = -t; end
      endcase
      zi = {2'b00, z[29:0]};
    end
    for (int i = 0; i < 16; i++) begin
      d = mode ? (yi >= 0) : zi[31];
      if (d) begin
        t = xi + (yi >>> i); yi = yi - (xi >>> i); xi = t; zi = zi + atan_tb[i];
      end else begin
        t = xi - (yi >>> i); yi = yi + (xi >>> i); xi = t; zi = zi - atan_tb[i];
      end
    end
    e.x = sat32(xi);
    e.y = sat32(yi);
    e.z = zi;
    e.tag = tag;
    e.mode = mode;
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    e.chk_real = 1'b0;
    e.rx = 0.0;
    e.ry = 0.0;
    e.mag = 0.0;
    e.rz = 32'h0;
    return e;
  endfunction

  // Trigonometric reference: ideal rotation / polar conversion scaled by the gain.
  function automatic exp_t add_real(input exp_t ein, input logic mode, input logic [31:0] x,
                                    input logic [31:0] y, input logic [31:0] z);
    exp_t e;
    real  xr, yr, ang, th;
    e = ein;
    xr = real'($signed(x));
    yr = real'($signed(y));
    e.chk_real = 1'b1;
    e.mag = kgain * $sqrt(xr * xr + yr * yr);
    if (mode) begin
      ang = $atan2(yr, xr);
      if (ang < 0.0) ang = ang + 2.0 * PI;
      e.rx = clampr(e.mag);
      e.ry = 0.0;
      e.rz = 32'(longint'(ang / (2.0 * PI) * 4294967296.0));
    end else begin
      th = real'(z) / 4294967296.0 * 2.0 * PI;
      e.rx = clampr(kgain * (xr * $cos(th) - yr * $sin(th)));
      e.ry = clampr(kgain * (xr * $sin(th) + yr * $cos(th)));
      e.rz = 32'h0;
    end
    return e;
  endfunction

  // Monitor: a transfer happens on the posedge following a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got tag %0d with no beat outstanding", out_tag);
      end else begin
        mon_e = sb.pop_front();
        check("out_x", longint'(out_x), longint'(mon_e.x));
        check("out_y", longint'(out_y), longint'(mon_e.y));
        check("out_z", longint'(out_z), longint'(mon_e.z));
        check("out_tag", longint'(out_tag), longint'(mon_e.tag));
        check("out_mode", longint'(out_mode), longint'(mon_e.mode));
        if (mon_e.chk_lat) check("latency", longint'(cyc - mon_e.acc_cyc), 17);
        if (mon_e.chk_real) begin
          check_tol("real_x", longint'($signed(out_x)), mon_e.rx, 256.0 + mon_e.mag / 16384.0);
          check_tol("real_y", longint'($signed(out_y)), mon_e.ry, 256.0 + mon_e.mag / 16384.0);
          check_tol("real_z", longint'($signed(out_z - mon_e.rz)), 0.0, 131072.0);
        end
      end
    end
  end

  task automatic send(input logic mode, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic [3:0] tag, input bit lat, input bit rchk);
    exp_t e;
    int   guard;
    e = model(mode, x, y, z, tag);
    e.chk_lat = lat;
    if (rchk) e = add_real(e, mode, x, y, z);
    in_valid = 1'b1;
    in_mode = mode;
    in_x = x;
    in_y = y;
    in_z = z;
    in_tag = tag;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 for tag %0d", tag);
    end else begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    check({name, "_drained"}, longint'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_idle"}, longint'(out_valid), 0);
  endtask

  task automatic send_rand(input logic [3:0] tag, input bit lat);
    logic [31:0] rx, ry;
    rx = 32'($signed($urandom()) >>> $urandom_range(0, 12));
    ry = 32'($signed($urandom()) >>> $urandom_range(0, 12));
    send(1'($urandom_range(0, 1)), rx, ry, $urandom(), tag, lat, 1'b0);
  endtask

  initial begin
    int n_before;
    for (int i = 0; i < 16; i++)
      atan_tb[i] = 32'($rtoi($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * PI) + 0.5));
    kgain = 1.0;
    for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_x", longint'(out_x), 0);
    check("rst_out_y", longint'(out_y), 0);
    check("rst_out_z", longint'(out_z), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    check("rst_out_mode", longint'(out_mode), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, downstream always ready.
    send(1'b0, 32'd1000000, 32'd0, 32'h2000_0000, 4'd1, 1'b1, 1'b1);
    send(1'b0, 32'd1000000, 32'd0, 32'hC000_0000, 4'd2, 1'b1, 1'b1);
    send(1'b0, 32'd1000000, 32'd0, 32'h4000_0000, 4'd3, 1'b1, 1'b1);
    send(1'b0, 32'd1000000, 32'd0, 32'h8000_0000, 4'd4, 1'b1, 1'b1);
    send(1'b1, -32'sd30000, -32'sd40000, 32'hDEAD_BEEF, 4'd5, 1'b1, 1'b1);
    send(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, 4'd6, 1'b1, 1'b1);
    send(1'b0, 32'h8000_0000, 32'd0, 32'h8000_0000, 4'd7, 1'b1, 1'b1);
    send(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'd8, 1'b1, 1'b1);
    send(1'b0, 32'd12345, -32'sd6789, 32'h6000_0000, 4'd9, 1'b1, 1'b1);
    wait_drain("directed");

    // Random stream with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_rand(4'(i), 1'b0);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
    wait_drain("random");
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with the pipe full: in-flight beats must vanish.
    for (int i = 0; i < 20; i++) send_rand(4'(i), 1'b1);
    check("pre_reset_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_x", longint'(out_x), 0);
    check("reset_out_tag", longint'(out_tag), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_before = n_out;
    for (int i = 0; i < 10; i++) send_rand(4'(15 - i), 1'b1);
    wait_drain("post_reset");
    check("post_reset_count", longint'(n_out - n_before), 10);

    check("queue_empty", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
